// File: rtl/bus_arb_8_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter.
// Holds the requester count, the owner-index width, the arbiter state
// encoding and a small index-to-one-hot helper.
package bus_arb_8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin search over 8 request lines.
// Ports:
//   req_i   - request mask to search
//   ptr_i   - index with highest priority; priority falls off as ptr, ptr+1, ... mod 8
//   found_o - at least one bit of req_i is set
//   idx_o   - index of the winning request (ptr_i when nothing is found)
module rr_pick8
  import bus_arb_8_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest-priority position to the highest so the last hit
  // written is the winner; avoids an early exit from the loop.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr_i + SEL_W'(i);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arb_8.sv
// Eight-requester round-robin bus arbiter with hold-time preemption.
// A requester keeps the bus while its req bit stays high; after MAX_HOLD grant
// cycles it is preempted if another requester is waiting and lock is low.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   req     - per-requester request, held high for the whole transfer
//   lock    - suppresses preemption of the current owner while high
//   gnt     - registered one-hot grant, zero when idle
//   sel     - registered owner index for the shared datapath mux
//   busy    - high while a grant is active
//   preempt - one-cycle pulse in the first cycle after a forced revocation
module bus_arb_8
  import bus_arb_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             lock,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             preempt
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             preempt_q, preempt_d;

  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // While granted, the next owner is always searched from sel+1 with the
  // current owner masked out: on release its bit is already low, and on
  // preemption it must lose to every other requester.
  always_comb begin
    if (state_q == StGrant) begin
      pick_req = req & ~sel_onehot(sel_q);
      pick_ptr = sel_q + SEL_W'(1);
    end else begin
      pick_req = req;
      pick_ptr = ptr_q;
    end
  end

  rr_pick8 u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StGrant;
          gnt_d      = sel_onehot(pick_idx);
          sel_d      = pick_idx;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end

      StGrant: begin
        if (!req[sel_q]) begin
          // Release: hand over on the same edge, or drop to idle keeping sel.
          ptr_d = sel_q + SEL_W'(1);
          if (pick_found) begin
            gnt_d      = sel_onehot(pick_idx);
            sel_d      = pick_idx;
            hold_cnt_d = 8'd1;
          end else begin
            state_d    = StIdle;
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = 8'd0;
          end
        end else if ((hold_cnt_q == MaxHold) && !lock && pick_found) begin
          ptr_d      = sel_q + SEL_W'(1);
          gnt_d      = sel_onehot(pick_idx);
          sel_d      = pick_idx;
          hold_cnt_d = 8'd1;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q < MaxHold) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = StIdle;
        gnt_d      = '0;
        busy_d     = 1'b0;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arb_8.sv
// Self-checking bench for bus_arb_8: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural arbiter model.
module tb_bus_arb_8;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  bus_arb_8 #(.MAX_HOLD(MaxHold)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
  endtask

  // Behavioural model: owner -1 means idle.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_pre   = 1'b0;

  function automatic int rr_search(input logic [7:0] r, input int start, input int skip);
    for (int k = 0; k < 8; k++) begin
      int c = (start + k) % 8;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int w;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_pre = 1'b0;
      end else begin
        m_pre = 1'b0;
        if (m_owner < 0) begin
          w = rr_search(req, m_ptr, -1);
          if (w >= 0) begin m_owner = w; m_sel = w; m_hold = 1; end
        end else if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 8;
          w = rr_search(req, m_ptr, -1);
          if (w >= 0) begin m_owner = w; m_sel = w; m_hold = 1; end
          else begin m_owner = -1; m_hold = 0; end
        end else if (m_hold == int'(MaxHold) && !lock &&
                     rr_search(req, (m_owner + 1) % 8, m_owner) >= 0) begin
          m_ptr = (m_owner + 1) % 8;
          w = rr_search(req, m_ptr, m_owner);
          m_owner = w; m_sel = w; m_hold = 1; m_pre = 1'b1;
        end else if (m_hold < int'(MaxHold)) begin
          m_hold++;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    logic [7:0] exp_gnt;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("model_gnt", gnt, exp_gnt);
        check("model_sel", sel, m_sel);
        check("model_busy", busy, (m_owner >= 0));
        check("model_preempt", preempt, m_pre);
        check("gnt_sel_eq_busy", gnt[sel], busy);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] own_bit;

  initial begin
    int e;
    int b;
    rst = 1'b1; req = 8'h00; lock = 1'b0;
    step(2);
    started = 1'b1;
    check("reset_gnt", gnt, 8'h00);
    check("reset_busy", busy, 1'b0);

    // Idle single request and release.
    rst = 1'b0; req = 8'h10;
    step(1);
    check("single_gnt", gnt, 8'h10);
    check("single_sel", sel, 3'd4);
    check("single_busy", busy, 1'b1);
    req = 8'h00;
    step(1);
    check("single_rel_gnt", gnt, 8'h00);
    check("single_rel_busy", busy, 1'b0);
    check("single_rel_sel", sel, 3'd4);

    // Round-robin between 0 and 7, three grant cycles each.
    rst = 1'b1; step(1); rst = 1'b0;
    req = 8'h81;
    step(1);
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 0 : 7;
      own_bit = 8'h01 << e;
      check("rr_owner", gnt, own_bit);
      check("rr_busy", busy, 1'b1);
      step(2);
      req = 8'h81 & ~own_bit;
      step(1);
      req = 8'h81;
    end
    check("rr_final", gnt, 8'h01);

    // Preemption after MAX_HOLD grant cycles.
    rst = 1'b1; req = 8'h00; step(1); rst = 1'b0;
    req = 8'h04;
    step(1);
    check("pre_first", gnt, 8'h04);
    step(1);
    req = 8'h24;
    step(2);
    check("pre_hold_gnt", gnt, 8'h04);
    check("pre_hold_pulse", preempt, 1'b0);
    step(1);
    check("pre_move_gnt", gnt, 8'h20);
    check("pre_move_pulse", preempt, 1'b1);
    step(1);
    check("pre_after_gnt", gnt, 8'h20);
    check("pre_after_pulse", preempt, 1'b0);

    // Same stimulus under lock: no preemption.
    rst = 1'b1; req = 8'h00; step(1); rst = 1'b0;
    lock = 1'b1; req = 8'h04;
    step(2);
    req = 8'h24;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("lock_gnt", gnt, 8'h04);
      check("lock_pulse", preempt, 1'b0);
    end

    // Lone requester held long past saturation.
    lock = 1'b0; req = 8'h04;
    for (int k = 0; k < 40; k++) begin
      step(1);
      check("lone_gnt", gnt, 8'h04);
      check("lone_pulse", preempt, 1'b0);
    end

    // Reset mid-grant, then arbitration restarts from ptr 0.
    rst = 1'b1; req = 8'h00; step(1); rst = 1'b0;
    req = 8'h08;
    step(1);
    check("rstmid_gnt", gnt, 8'h08);
    step(2);
    rst = 1'b1;
    step(1);
    check("rstmid_drop_gnt", gnt, 8'h00);
    check("rstmid_drop_busy", busy, 1'b0);
    check("rstmid_drop_sel", sel, 3'd0);
    rst = 1'b0; req = 8'h09;
    step(1);
    check("rstmid_resume_gnt", gnt, 8'h01);
    check("rstmid_resume_sel", sel, 3'd0);

    // Randomized traffic checked against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 7);
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 19) == 0) lock = ~lock;
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
